// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow clock or tick
// input (clk_in) in system-clock cycles.
//
// Parameters:
//   TIMEOUT    busy-cycle limit before a measurement is abandoned (2 .. 2^32-1)
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   clk_in     slow input being measured, asynchronous to clk
//   start      single-cycle request; accepted only while idle
//   cont       continuous mode, sampled at each measurement's closing rise
//   period     last measured period (clk cycles)
//   high_time  last measured high time (clk cycles)
//   valid      one-cycle pulse when period/high_time update
//   busy       measurement in progress
//   timeout    sticky flag: last measurement abandoned; cleared by next start
module clk_period_meter #(
  parameter int unsigned TIMEOUT = 32'd20000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_in,
  input  logic        start,
  input  logic        cont,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic        valid,
  output logic        busy,
  output logic        timeout
);

  localparam logic [31:0] TermCnt = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWaitRise, StMeasure} state_e;

  state_e      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic        rise;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hcnt_q, hcnt_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] period_q, period_d;
  logic [31:0] high_q, high_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= clk_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    tcnt_d    = tcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tcnt_d    = '0;
          timeout_d = 1'b0;
          state_d   = StWaitRise;
        end
      end

      StWaitRise: begin
        tcnt_d = tcnt_q + 32'd1;
        if (rise) begin
          cnt_d   = 32'd1;
          hcnt_d  = 32'd1;
          state_d = StMeasure;
        end else if (tcnt_q >= TermCnt) begin
          // >= rather than == so a rise landing on the terminal count here
          // cannot push tcnt past the limit and disable the timeout.
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end

      StMeasure: begin
        tcnt_d = tcnt_q + 32'd1;
        if (rise) begin
          // Rise wins over a coincident terminal count.
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          if (cont) begin
            // Closing rise doubles as the opening rise of the next period.
            cnt_d  = 32'd1;
            hcnt_d = 32'd1;
            tcnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (tcnt_q >= TermCnt) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (s2_q) begin
            hcnt_d = hcnt_q + 32'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      tcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      tcnt_q    <= tcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign busy      = (state_q != StIdle);
  assign timeout   = timeout_q;

endmodule
